ibex_irq_arbiter: RTL and testbench

- Interrupt arbiter between the `irqs_t` sources plus NMI and the ID-stage controller.
- Tracks pending state per source, with level or edge capture for each fast interrupt.
- Applies `mie` and `mstatus.MIE` masking, priority-selects one cause and presents it to the controller with a request/acknowledge handshake.
- Supplies the `mip` view to the CSR file.

---
 rtl/ibex_irq_arbiter_if.sv | 28 ++
 rtl/ibex_irq_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ibex_irq_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ibex_irq_arbiter_if.sv
// Signal bundle between the interrupt sources / CSR file and the arbiter,
// plus the controller-facing request/acknowledge pair.
interface ibex_irq_arbiter_if;
    // Handshake: irq_req_o rises with a stable irq_cause_o/irq_nm_o and stays
    // high until irq_ack_i is sampled high in the same cycle; ack is only
    // honoured while a request is up, and the request drops the cycle after.
    logic [17:0] irqs_i;
    logic        irq_nm_i;
    logic [17:0] mie_i;
    logic        mstatus_mie_i;
    logic        debug_mode_i;
    logic        irq_ack_i;
    logic [17:0] mip_o;
    logic        irq_req_o;
    logic        irq_nm_o;
    logic [5:0]  irq_cause_o;
    logic [1:0]  fsm_state;

    modport master (
        output irqs_i, irq_nm_i, mie_i, mstatus_mie_i, debug_mode_i, irq_ack_i,
        input  mip_o, irq_req_o, irq_nm_o, irq_cause_o, fsm_state
    );

    modport slave (
        input  irqs_i, irq_nm_i, mie_i, mstatus_mie_i, debug_mode_i, irq_ack_i,
        output mip_o, irq_req_o, irq_nm_o, irq_cause_o, fsm_state
    );
endinterface

// File: rtl/ibex_irq_arbiter.sv
// Interrupt arbiter: pending capture, masking, fixed-priority selection and a
// registered request/acknowledge towards the ID-stage controller.
module ibex_irq_arbiter #(
    parameter logic [14:0] FastEdgeMask = 15'h0000,
    parameter bit          NmiEnable    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ibex_irq_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [17:0] irq_q;
    logic [14:0] fast_latch_q, fast_latch_d, fast_rise, fast_clr, fast_pend;
    logic        nmi_prev_q, nmi_q, nmi_d, nmi_rise, nmi_clr;
    logic        req_q, req_d, nm_q, nm_d;
    logic [5:0]  cause_q, cause_d;
    logic [17:0] mip, elig;
    logic        nmi_elig, any_elig, held_elig, win_nm, ack_taken;
    logic [5:0]  win_cause;

    assign ack_taken = (state_q == REQ) && bus.irq_ack_i;

    // irq_q doubles as the previous-cycle sample for edge detection.
    assign fast_rise = bus.irqs_i[14:0] & ~irq_q[14:0];

    always_comb begin
        fast_clr = '0;
        for (int k = 0; k < 15; k++) begin
            if (ack_taken && !nm_q && cause_q == {1'b1, 5'(16 + k)}) begin
                fast_clr[k] = 1'b1;
            end
        end
    end

    assign fast_latch_d = ((fast_latch_q & ~fast_clr) | fast_rise) & FastEdgeMask;
    assign fast_pend    = (fast_latch_q & FastEdgeMask) | (irq_q[14:0] & ~FastEdgeMask);
    assign mip          = {irq_q[17:15], fast_pend};

    assign nmi_rise = NmiEnable && bus.irq_nm_i && !nmi_prev_q;
    assign nmi_clr  = ack_taken && nm_q;
    assign nmi_d    = (nmi_q && !nmi_clr) || nmi_rise;

    assign elig     = mip & bus.mie_i & {18{bus.mstatus_mie_i && !bus.debug_mode_i}};
    assign nmi_elig = nmi_q && !bus.debug_mode_i;
    assign any_elig = nmi_elig || (|elig);

    // Bit layout: [17] software, [16] timer, [15] external, [14:0] fast.
    always_comb begin
        win_nm    = 1'b0;
        win_cause = 6'd0;
        if (nmi_elig) begin
            win_nm    = 1'b1;
            win_cause = {1'b1, 5'd31};
        end else if (elig[15]) begin
            win_cause = {1'b1, 5'd11};
        end else if (elig[17]) begin
            win_cause = {1'b1, 5'd3};
        end else if (elig[16]) begin
            win_cause = {1'b1, 5'd7};
        end else begin
            for (int k = 14; k >= 0; k--) begin
                if (elig[k]) win_cause = {1'b1, 5'(16 + k)};
            end
        end
    end

    always_comb begin
        held_elig = 1'b0;
        if (nm_q) begin
            held_elig = nmi_elig;
        end else begin
            case (cause_q[4:0])
                5'd3:    held_elig = elig[17];
                5'd7:    held_elig = elig[16];
                5'd11:   held_elig = elig[15];
                default: begin
                    for (int k = 0; k < 15; k++) begin
                        if (cause_q[4:0] == 5'(16 + k)) held_elig = elig[k];
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cause_d = cause_q;
        nm_d    = nm_q;
        case (state_q)
            IDLE: begin
                req_d   = 1'b0;
                cause_d = 6'd0;
                nm_d    = 1'b0;
                if (any_elig) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    cause_d = win_cause;
                    nm_d    = win_nm;
                end
            end
            REQ: begin
                if (bus.irq_ack_i) begin
                    state_d = HOLD;
                    req_d   = 1'b0;
                end else if ((nmi_elig && !nm_q) || (!held_elig && any_elig)) begin
                    cause_d = win_cause;
                    nm_d    = win_nm;
                end else if (!held_elig) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    cause_d = 6'd0;
                    nm_d    = 1'b0;
                end
            end
            HOLD: begin
                state_d = IDLE;
                req_d   = 1'b0;
                cause_d = 6'd0;
                nm_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                cause_d = 6'd0;
                nm_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            irq_q        <= '0;
            fast_latch_q <= '0;
            nmi_prev_q   <= 1'b0;
            nmi_q        <= 1'b0;
            req_q        <= 1'b0;
            cause_q      <= 6'd0;
            nm_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_q        <= bus.irqs_i;
            fast_latch_q <= fast_latch_d;
            nmi_prev_q   <= NmiEnable && bus.irq_nm_i;
            nmi_q        <= nmi_d;
            req_q        <= req_d;
            cause_q      <= cause_d;
            nm_q         <= nm_d;
        end
    end

    assign bus.mip_o       = mip;
    assign bus.irq_req_o   = req_q;
    assign bus.irq_nm_o    = nm_q;
    assign bus.irq_cause_o = cause_q;
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Directed bench for ibex_irq_arbiter with fast[0] edge-sensitive.
module tb_ibex_irq_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    localparam logic [17:0] SW = 18'h20000, TMR = 18'h10000, EXT = 18'h08000;
    localparam logic [1:0]  S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2;

    ibex_irq_arbiter_if bus ();

    ibex_irq_arbiter #(.FastEdgeMask(15'h0001), .NmiEnable(1'b1)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic req, input logic nm,
                             input logic [5:0] cause, input logic [1:0] st);
        check({tag, "_req"}, 32'(bus.irq_req_o), 32'(req));
        check({tag, "_nm"}, 32'(bus.irq_nm_o), 32'(nm));
        check({tag, "_cause"}, 32'(bus.irq_cause_o), 32'(cause));
        check({tag, "_state"}, 32'(bus.fsm_state), 32'(st));
    endtask

    initial begin
        bus.irqs_i = '0; bus.irq_nm_i = 1'b0; bus.mie_i = '0;
        bus.mstatus_mie_i = 1'b0; bus.debug_mode_i = 1'b0; bus.irq_ack_i = 1'b0;
        tick(); tick();
        check_req("reset", 1'b0, 1'b0, 6'h00, S_IDLE);
        check("reset_mip", 32'(bus.mip_o), 32'h0);
        rst_n = 1'b1;
        tick();

        // Priority: software beats timer and fast[3]
        bus.mie_i = '1; bus.mstatus_mie_i = 1'b1;
        bus.irqs_i = SW | TMR | 18'h00008;
        tick();
        check("prio_mip", 32'(bus.mip_o), 32'h30008);
        check("prio_req_early", 32'(bus.irq_req_o), 32'h0);
        tick();
        check_req("prio", 1'b1, 1'b0, 6'h23, S_REQ);

        // Ack software, expect HOLD, IDLE, then timer
        bus.irq_ack_i = 1'b1; bus.irqs_i = TMR | 18'h00008;
        tick();
        check_req("ack_hold", 1'b0, 1'b0, 6'h23, S_HOLD);
        bus.irq_ack_i = 1'b0;
        tick();
        check_req("ack_idle", 1'b0, 1'b0, 6'h00, S_IDLE);
        tick();
        check_req("ack_timer", 1'b1, 1'b0, 6'h27, S_REQ);
        bus.irq_ack_i = 1'b1; bus.irqs_i = '0;
        tick();
        bus.irq_ack_i = 1'b0;
        tick(); tick();
        check_req("quiet", 1'b0, 1'b0, 6'h00, S_IDLE);

        // Edge capture on fast[0]
        bus.mstatus_mie_i = 1'b0;
        bus.irqs_i = 18'h1; tick();
        bus.irqs_i = '0; tick(); tick();
        check("edge_mip_held", 32'(bus.mip_o), 32'h1);
        check("edge_no_req", 32'(bus.irq_req_o), 32'h0);
        bus.mstatus_mie_i = 1'b1;
        tick();
        check_req("edge_req", 1'b1, 1'b0, 6'h30, S_REQ);
        bus.irq_ack_i = 1'b1;
        tick();
        check("edge_ack_clear", 32'(bus.mip_o), 32'h0);
        bus.irq_ack_i = 1'b0;
        tick();
        bus.irqs_i = 18'h1; tick();
        bus.irqs_i = '0; tick();
        check_req("edge_req2", 1'b1, 1'b0, 6'h30, S_REQ);
        bus.irq_ack_i = 1'b1; bus.irqs_i = 18'h1;
        tick();
        check("edge_ack_rise_mip", 32'(bus.mip_o), 32'h1);
        check("edge_ack_rise_state", 32'(bus.fsm_state), 32'(S_HOLD));
        bus.irq_ack_i = 1'b0; bus.irqs_i = '0;
        tick(); tick();
        check_req("edge_req3", 1'b1, 1'b0, 6'h30, S_REQ);
        bus.mstatus_mie_i = 1'b0;
        tick();
        check_req("edge_mask_idle", 1'b0, 1'b0, 6'h00, S_IDLE);
        bus.mstatus_mie_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b1; tick();
        bus.irq_ack_i = 1'b0; tick();
        check("edge_drained", 32'(bus.mip_o), 32'h0);

        // NMI preempts a held external request, ignoring mstatus.MIE
        bus.irqs_i = EXT;
        tick(); tick();
        check_req("ext_req", 1'b1, 1'b0, 6'h2B, S_REQ);
        bus.irq_nm_i = 1'b1;
        tick();
        bus.irq_nm_i = 1'b0; bus.mstatus_mie_i = 1'b0;
        tick();
        check_req("nmi_preempt", 1'b1, 1'b1, 6'h3F, S_REQ);
        tick();
        check_req("nmi_stable", 1'b1, 1'b1, 6'h3F, S_REQ);
        bus.irq_ack_i = 1'b1;
        tick();
        check_req("nmi_hold", 1'b0, 1'b1, 6'h3F, S_HOLD);
        bus.irq_ack_i = 1'b0;
        tick(); tick();
        check_req("nmi_done", 1'b0, 1'b0, 6'h00, S_IDLE);
        bus.irqs_i = '0;

        // Withdraw a level timer request
        bus.mstatus_mie_i = 1'b1; bus.irqs_i = TMR;
        tick(); tick();
        check_req("wd_req", 1'b1, 1'b0, 6'h27, S_REQ);
        bus.irqs_i = '0;
        tick(); tick();
        check_req("wd_idle", 1'b0, 1'b0, 6'h00, S_IDLE);

        // Debug mode masks everything, including NMI
        bus.debug_mode_i = 1'b1; bus.irqs_i = '1; bus.irq_nm_i = 1'b1;
        tick();
        bus.irq_nm_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dbg_no_req", 32'(bus.irq_req_o), 32'h0);
        end
        check("dbg_mip", 32'(bus.mip_o), 32'h3FFFF);
        bus.debug_mode_i = 1'b0;
        tick();
        check_req("dbg_exit_nmi", 1'b1, 1'b1, 6'h3F, S_REQ);

        // Asynchronous reset mid-request
        #2 rst_n = 1'b0;
        #1;
        check_req("async_rst", 1'b0, 1'b0, 6'h00, S_IDLE);
        check("async_rst_mip", 32'(bus.mip_o), 32'h0);
        bus.irqs_i = '0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check_req("post_rst", 1'b0, 1'b0, 6'h00, S_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
